// File: rtl/vec_wb_pkg.sv
// Shared types and constants for the vector register-file write side.
package vec_wb_pkg;
  localparam int DATA_W     = 128;
  localparam int ADDR_W     = 4;
  localparam int NUM_REGS   = 15;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic {SRC_ALU, SRC_MEM} src_e;

  function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
    return int'(a) < NUM_REGS;
  endfunction
endpackage

// File: rtl/vec_wb_if.sv
// Result channel from a producer (ALU or load path) into the writeback unit.
interface vec_wb_if;
  logic                          valid;
  logic                          ready;
  logic [vec_wb_pkg::ADDR_W-1:0] addr;
  logic [vec_wb_pkg::DATA_W-1:0] data;

  modport master (output valid, addr, data, input ready);
  modport slave  (input valid, addr, data, output ready);
endinterface

// File: rtl/wb_fifo.sv
// Small result FIFO; per-slot valid bits and addresses feed the hazard mask.
module wb_fifo import vec_wb_pkg::*; #(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  wb_entry_t                din,
  input  logic                     pop,
  output wb_entry_t                dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [DEPTH-1:0]         ent_vld,
  output logic [ADDR_W-1:0]        ent_addr [DEPTH]
);
  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wp, rp;

  assign full  = (count == DEPTH[PTR_W:0]);
  assign empty = (count == '0);
  assign dout  = mem[rp];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_addr[i] = mem[i].addr;
  end

  // Storage is not reset; ent_vld alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp      <= '0;
      rp      <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else begin
      if (push) begin
        wp          <= wp + 1'b1;
        ent_vld[wp] <= 1'b1;
      end
      if (pop) begin
        rp          <= rp + 1'b1;
        ent_vld[rp] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/vec_writeback_unit.sv
// Round-robin ALU/load arbitration into a result FIFO that drives the RF write port.
module vec_writeback_unit import vec_wb_pkg::*; (
  input  logic                    clk,
  input  logic                    rst,
  vec_wb_if.slave                 alu,
  vec_wb_if.slave                 mem,
  output logic                    rf_we,
  output logic [ADDR_W-1:0]       rf_waddr,
  output logic [DATA_W-1:0]       rf_wdata,
  output logic [(1<<ADDR_W)-1:0]  pending,
  output logic [CNT_W-1:0]        fifo_count,
  output logic                    bad_addr
);
  src_e             rr;
  logic             alu_win, mem_win, contested, accept, legal, push, pop;
  logic             full, empty;
  wb_entry_t        sel, head;
  logic [FIFO_DEPTH-1:0] ent_vld;
  logic [ADDR_W-1:0]     ent_addr [FIFO_DEPTH];

  assign contested = alu.valid && mem.valid;
  assign alu_win   = alu.valid && (!mem.valid || rr == SRC_ALU);
  assign mem_win   = mem.valid && !alu_win;
  // Full blocks acceptance even when the head drains this cycle.
  assign alu.ready = alu_win && !full;
  assign mem.ready = mem_win && !full;
  assign accept    = alu.ready || mem.ready;

  always_comb begin
    sel = alu_win ? '{addr: alu.addr, data: alu.data}
                  : '{addr: mem.addr, data: mem.data};
  end

  assign legal = addr_legal(sel.addr);
  assign push  = accept && legal;
  assign pop   = !empty;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .din      (sel),
    .pop      (pop),
    .dout     (head),
    .count    (fifo_count),
    .full     (full),
    .empty    (empty),
    .ent_vld  (ent_vld),
    .ent_addr (ent_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr       <= SRC_ALU;
      bad_addr <= 1'b0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      if (contested && accept) rr <= (rr == SRC_ALU) ? SRC_MEM : SRC_ALU;
      bad_addr <= accept && !legal;
      rf_we    <= !empty;
      if (!empty) begin
        rf_waddr <= head.addr;
        rf_wdata <= head.data;
      end
    end
  end

  // Buffered entries plus the write currently on the port; illegal addresses never get here.
  always_comb begin
    pending = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (ent_vld[i]) pending[ent_addr[i]] = 1'b1;
    if (rf_we) pending[rf_waddr] = 1'b1;
  end
endmodule
